// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: serial scan controller with separate instruction (IR) and
// data (DR) paths and a capture/shift/update datapath. The instruction selects
// one of NCH parallel DW-bit channels, or a 1-bit bypass when ir >= NCH.
//
// Ports:
//   clk      rising-edge clock
//   rs       synchronous active-high reset
//   x        state-control input, sampled every edge
//   tdi      serial data in
//   cap_in   parallel capture data, channel c at [c*DW +: DW]
//   tdo      serial data out (combinational from state and shift registers)
//   reset, run, capture, shift, update   state decode flags (registered)
//   ir_sel   high in the IR-path states
//   ir       current instruction
//   par_out  updated channel registers, channel c at [c*DW +: DW]
module scan_chain_ctrl #(
   parameter int unsigned DW  = 8,
   parameter int unsigned NCH = 4,
   parameter int unsigned IRW = 3
) (
   input  logic                clk,
   input  logic                rs,
   input  logic                x,
   input  logic                tdi,
   input  logic [NCH*DW-1:0]   cap_in,
   output logic                tdo,
   output logic                reset,
   output logic                run,
   output logic                capture,
   output logic                shift,
   output logic                update,
   output logic                ir_sel,
   output logic [IRW-1:0]      ir,
   output logic [NCH*DW-1:0]   par_out
);

   localparam int unsigned PW = NCH * DW;

   localparam logic [3:0] ST_RS   = 4'd0;
   localparam logic [3:0] ST_RI   = 4'd1;
   localparam logic [3:0] ST_SDR  = 4'd2;
   localparam logic [3:0] ST_SIR  = 4'd3;
   localparam logic [3:0] ST_CDR  = 4'd4;
   localparam logic [3:0] ST_CIR  = 4'd5;
   localparam logic [3:0] ST_SHDR = 4'd6;
   localparam logic [3:0] ST_SHIR = 4'd7;
   localparam logic [3:0] ST_UDR  = 4'd8;
   localparam logic [3:0] ST_UIR  = 4'd9;

   logic [3:0]     state;
   logic [3:0]     state_d;
   logic           reset_d, run_d, capture_d, shift_d, update_d, ir_sel_d;

   logic [IRW-1:0] ir_q;
   logic [IRW-1:0] ir_sr;
   logic [DW-1:0]  dr_sr;
   logic           byp;
   logic [PW-1:0]  par_q;

   logic           bypass_c;
   logic [DW-1:0]  cap_sel_c;

   // Out-of-range instructions route the DR path through the bypass bit.
   assign bypass_c = (ir_q >= IRW'(NCH));

   // Capture mux: channel selected by the current instruction.
   always_comb begin
      cap_sel_c = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (ir_q == IRW'(c)) cap_sel_c = cap_in[c*DW +: DW];
      end
   end

   // Next-state logic; flags are decoded from the next state and registered.
   always_comb begin
      state_d   = state;
      reset_d   = 1'b0;
      run_d     = 1'b0;
      capture_d = 1'b0;
      shift_d   = 1'b0;
      update_d  = 1'b0;
      ir_sel_d  = 1'b0;

      unique case (state)
         ST_RS:   state_d = x ? ST_RS   : ST_RI;
         ST_RI:   state_d = x ? ST_SDR  : ST_RI;
         ST_SDR:  state_d = x ? ST_SIR  : ST_CDR;
         ST_SIR:  state_d = x ? ST_RS   : ST_CIR;
         ST_CDR:  state_d = x ? ST_UDR  : ST_SHDR;
         ST_CIR:  state_d = x ? ST_UIR  : ST_SHIR;
         ST_SHDR: state_d = x ? ST_UDR  : ST_SHDR;
         ST_SHIR: state_d = x ? ST_UIR  : ST_SHIR;
         ST_UDR:  state_d = x ? ST_SDR  : ST_RI;
         ST_UIR:  state_d = x ? ST_SDR  : ST_RI;
         default: state_d = ST_RS;
      endcase

      if (rs) state_d = ST_RS;

      reset_d   = (state_d == ST_RS);
      run_d     = (state_d == ST_RI);
      capture_d = (state_d == ST_CDR)  || (state_d == ST_CIR);
      shift_d   = (state_d == ST_SHDR) || (state_d == ST_SHIR);
      update_d  = (state_d == ST_UDR)  || (state_d == ST_UIR);
      ir_sel_d  = (state_d == ST_SIR)  || (state_d == ST_CIR) ||
                  (state_d == ST_SHIR) || (state_d == ST_UIR);
   end

   // State and flag registers.
   always_ff @(posedge clk) begin
      state   <= state_d;
      reset   <= reset_d;
      run     <= run_d;
      capture <= capture_d;
      shift   <= shift_d;
      update  <= update_d;
      ir_sel  <= ir_sel_d;
   end

   // Capture/shift/update datapath, acting on the state the edge ends.
   always_ff @(posedge clk) begin
      if (rs) begin
         ir_q  <= '0;
         ir_sr <= '0;
         dr_sr <= '0;
         byp   <= 1'b0;
         par_q <= '0;
      end else begin
         unique case (state)
            ST_CDR: begin
               if (bypass_c) byp   <= 1'b0;
               else          dr_sr <= cap_sel_c;
            end
            ST_CIR:  ir_sr <= ir_q;
            ST_SHDR: begin
               if (bypass_c) byp   <= tdi;
               else          dr_sr <= {tdi, dr_sr[DW-1:1]};
            end
            ST_SHIR: ir_sr <= {tdi, ir_sr[IRW-1:1]};
            ST_UDR: begin
               for (int unsigned c = 0; c < NCH; c++) begin
                  if (!bypass_c && (ir_q == IRW'(c))) par_q[c*DW +: DW] <= dr_sr;
               end
            end
            ST_UIR:  ir_q <= ir_sr;
            default: ;
         endcase

         // Entering RS through x clears the instruction but keeps channels.
         if (state_d == ST_RS) ir_q <= '0;
      end
   end

   // Serial output: only meaningful while shifting.
   always_comb begin
      tdo = 1'b0;
      if (state == ST_SHDR)      tdo = bypass_c ? byp : dr_sr[0];
      else if (state == ST_SHIR) tdo = ir_sr[0];
   end

   assign ir      = ir_q;
   assign par_out = par_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: directed scenarios followed by a randomized run,
// all compared against a table-driven behavioural model.
module tb_scan_chain_ctrl;

   localparam int DW  = 8;
   localparam int NCH = 4;
   localparam int IRW = 3;
   localparam int PW  = NCH * DW;

   logic           clk;
   logic           rs;
   logic           x;
   logic           tdi;
   logic [PW-1:0]  cap_in;
   logic           tdo;
   logic           reset, run, capture, shift, update, ir_sel;
   logic [IRW-1:0] ir;
   logic [PW-1:0]  par_out;

   int checks;
   int failures;

   scan_chain_ctrl #(.DW(DW), .NCH(NCH), .IRW(IRW)) dut (
      .clk(clk), .rs(rs), .x(x), .tdi(tdi), .cap_in(cap_in),
      .tdo(tdo), .reset(reset), .run(run), .capture(capture),
      .shift(shift), .update(update), .ir_sel(ir_sel),
      .ir(ir), .par_out(par_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: states indexed 0..9 = RS RI SDR SIR CDR CIR SHDR SHIR UDR UIR.
   int nx0 [10] = '{1, 1, 4, 5, 6, 7, 6, 7, 1, 1};
   int nx1 [10] = '{0, 2, 3, 0, 8, 9, 8, 9, 2, 2};
   int ms;
   int m_ir, m_irsr, m_dr, m_byp;
   int m_par [NCH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic xi, input logic ti);
      int ch;
      bit bp;
      if (r) begin
         ms = 0; m_ir = 0; m_irsr = 0; m_dr = 0; m_byp = 0;
         for (int c = 0; c < NCH; c++) m_par[c] = 0;
         return;
      end
      ch = m_ir;
      bp = (m_ir >= NCH);
      case (ms)
         4: if (bp) m_byp = 0; else m_dr = int'(cap_in[ch*DW +: DW]);
         5: m_irsr = m_ir;
         6: if (bp) m_byp = int'(ti); else m_dr = (m_dr / 2) + int'(ti) * (1 << (DW-1));
         7: m_irsr = (m_irsr / 2) + int'(ti) * (1 << (IRW-1));
         8: if (!bp) m_par[ch] = m_dr;
         9: m_ir = m_irsr;
         default: ;
      endcase
      ms = xi ? nx1[ms] : nx0[ms];
      if (ms == 0) m_ir = 0;
   endtask

   task automatic check_model();
      logic [PW-1:0] ep;
      int et;
      for (int c = 0; c < NCH; c++) ep[c*DW +: DW] = DW'(m_par[c]);
      if (ms == 6)      et = (m_ir >= NCH) ? m_byp : (m_dr % 2);
      else if (ms == 7) et = m_irsr % 2;
      else              et = 0;
      chk("m_reset",   64'(reset),   64'(ms == 0));
      chk("m_run",     64'(run),     64'(ms == 1));
      chk("m_capture", 64'(capture), 64'(ms == 4 || ms == 5));
      chk("m_shift",   64'(shift),   64'(ms == 6 || ms == 7));
      chk("m_update",  64'(update),  64'(ms == 8 || ms == 9));
      chk("m_ir_sel",  64'(ir_sel),  64'(ms == 3 || ms == 5 || ms == 7 || ms == 9));
      chk("m_ir",      64'(ir),      64'(m_ir));
      chk("m_par_out", 64'(par_out), 64'(ep));
      chk("m_tdo",     64'(tdo),     64'(et));
   endtask

   // One clock: drive, edge, update model, sample #1 after the edge.
   task automatic step(input logic r, input logic xi, input logic ti);
      rs = r; x = xi; tdi = ti;
      @(posedge clk);
      model_edge(r, xi, ti);
      #1;
      check_model();
   endtask

   task automatic go_ri();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   // From RI: load an instruction LSB-first and return to RI.
   task automatic load_ir(input logic [IRW-1:0] val);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < IRW; i++) step(1'b0, (i == IRW-1), val[i]);
      chk("ir_update_on", 64'(update), 64'(1));
      step(1'b0, 1'b0, 1'b0);
      chk("ir_update_off", 64'(update), 64'(0));
      chk("ir_back_run", 64'(run), 64'(1));
      chk("ir_value", 64'(ir), 64'(val));
   endtask

   // From RI: capture, shift n bits of din, update, return to RI.
   task automatic shift_dr(input int n, input logic [DW-1:0] din, output logic [DW-1:0] seen);
      seen = '0;
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < n; k++) begin
         seen[k] = tdo;
         step(1'b0, (k == n-1), din[k]);
      end
      step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [DW-1:0] seen;
      logic [DW-1:0] capv;
      logic [PW-1:0] saved;
      int path_len [10] = '{3, 0, 1, 2, 2, 3, 3, 4, 3, 4};
      logic [3:0] path_x [10] = '{4'b0111, 4'b0000, 4'b0001, 4'b0011, 4'b0001,
                                   4'b0011, 4'b0001, 4'b0011, 4'b0101, 4'b1011};
      checks = 0; failures = 0;
      rs = 1'b1; x = 1'b0; tdi = 1'b0;
      cap_in = PW'({$urandom, $urandom});
      ms = 0; m_ir = 0; m_irsr = 0; m_dr = 0; m_byp = 0;
      for (int c = 0; c < NCH; c++) m_par[c] = 0;

      // Reset and leave to RI.
      step(1'b1, 1'b0, 1'b0);
      chk("rst_reset", 64'(reset), 64'(1));
      chk("rst_ir", 64'(ir), 64'(0));
      chk("rst_par", 64'(par_out), 64'(0));
      chk("rst_tdo", 64'(tdo), 64'(0));
      step(1'b0, 1'b0, 1'b0);
      chk("rst_run", 64'(run), 64'(1));

      // IR load of 2 with tdi 0,1,0.
      load_ir(IRW'(2));

      // DR write of 0xA5 into channel 2 capturing 0x3C.
      capv = 8'h3C;
      cap_in = PW'({$urandom, $urandom});
      cap_in[2*DW +: DW] = capv;
      saved = par_out;
      shift_dr(DW, 8'hA5, seen);
      chk("dr_tdo_seq", 64'(seen), 64'(capv));
      chk("dr_ch2", 64'(par_out[2*DW +: DW]), 64'(8'hA5));
      chk("dr_ch0", 64'(par_out[0 +: DW]), 64'(saved[0 +: DW]));
      chk("dr_ch1", 64'(par_out[DW +: DW]), 64'(saved[DW +: DW]));
      chk("dr_ch3", 64'(par_out[3*DW +: DW]), 64'(saved[3*DW +: DW]));

      // Bypass through ir=5: tdi 1,0,1 gives tdo 0,1,0.
      load_ir(IRW'(5));
      saved = par_out;
      shift_dr(3, 8'b0000_0101, seen);
      chk("byp_tdo_seq", 64'(seen[2:0]), 64'(3'b010));
      chk("byp_par", 64'(par_out), 64'(saved));

      // Five x=1 from each state lands in RS with ir cleared, channels kept.
      for (int s = 0; s < 10; s++) begin
         go_ri();
         load_ir(IRW'(5));
         for (int i = 0; i < path_len[s]; i++) step(1'b0, path_x[s][i], 1'($urandom));
         saved = par_out;
         for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom));
         chk("x5_reset", 64'(reset), 64'(1));
         chk("x5_ir", 64'(ir), 64'(0));
         chk("x5_par", 64'(par_out), 64'(saved));
      end

      // rs in the middle of a DR shift.
      go_ri();
      load_ir(IRW'(1));
      cap_in = PW'({$urandom, $urandom});
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'($urandom));
      step(1'b1, 1'b0, 1'b1);
      chk("mid_rst_reset", 64'(reset), 64'(1));
      chk("mid_rst_ir", 64'(ir), 64'(0));
      chk("mid_rst_par", 64'(par_out), 64'(0));
      chk("mid_rst_tdo", 64'(tdo), 64'(0));
      step(1'b0, 1'b0, 1'b0);
      chk("mid_rst_run", 64'(run), 64'(1));

      // Randomized traffic with occasional reset.
      for (int n = 0; n < 3000; n++) begin
         cap_in = PW'({$urandom, $urandom});
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Parametrised serial scan controller that succeeds the four-state reset/run/shift/update FSM. It adds capture and select states, separate instruction (IR) and data (DR) paths, and a capture/shift/update datapath. The instruction selects one of NCH parallel DW-bit data channels, or a 1-bit bypass. It sits between a serial test/configuration port (x, tdi, tdo) and the block registers it configures (par_out) and observes (cap_in).

## Interface
- DW, 8: width of each data channel.
- NCH, 4: number of data channels. Legal range is 1 ≤ NCH < 2^IRW.
- IRW, 3: instruction register width. IR values ≥ NCH select bypass.

- clk  in  1  clock. All state changes on rising edge.
- rs  in  1  reset. Synchronous, active-high.
- x  in  1  state-control input, sampled every rising edge.
- tdi  in  1  serial data in.
- cap_in  in  NCH*DW  parallel capture data. Channel c occupies bits [c*DW +: DW].
- tdo  out  1  serial data out.
- reset, run, capture, shift, update  out  1 each  state decode flags.
- ir_sel  out  1  1 while the FSM is in an IR-path state (SIR, CIR, SHIR, UIR).
- ir  out  IRW  current instruction.
- par_out  out  NCH*DW  updated channel registers.

## Operation
- States: RS, RI, SDR, SIR, CDR, CIR, SHDR, SHIR, UDR, UIR. State encoding is free.
- Transitions, written as x=0 / x=1:
  - RS: RI / RS
  - RI: RI / SDR
  - SDR: CDR / SIR
  - SIR: CIR / RS
  - CDR: SHDR / UDR
  - CIR: SHIR / UIR
  - SHDR: SHDR / UDR
  - SHIR: SHIR / UIR
  - UDR: RI / SDR
  - UIR: RI / SDR
- Five consecutive x=1 samples reach RS from any state.
- Outputs are Moore-style, decoded from state only:
  - reset=1 in RS.
  - run=1 in RI.
  - capture=1 in CDR and CIR.
  - shift=1 in SHDR and SHIR.
  - update=1 in UDR and UIR.
  - All other flags are 0.
- DR target: channel ir when ir < NCH; otherwise the bypass bit.
- CDR edge:
  - Normal channel: dr_sr ← cap_in channel ir.
  - Bypass: byp ← 0.
- CIR edge: ir_sr ← ir.
- SHDR edge, every cycle regardless of x:
  - Normal channel: dr_sr ← {tdi, dr_sr[DW-1:1]}.
  - Bypass: byp ← tdi.
- SHIR edge, every cycle regardless of x: ir_sr ← {tdi, ir_sr[IRW-1:1]}.
- UDR edge:
  - Normal channel: par_out channel ir ← dr_sr.
  - Bypass: no write.
  - Other channels are never disturbed.
- UIR edge: ir ← ir_sr. Out-of-range values are kept as-is and act as bypass.
- tdo, combinational:
  - SHDR: dr_sr[0], or byp when in bypass.
  - SHIR: ir_sr[0].
  - All other states: 0.
- Entering RS via x sets ir to 0 and keeps par_out.
- rs=1 effects at the next edge:
  - state ← RS.
  - ir, ir_sr, dr_sr, byp and all of par_out ← 0.
  - rs has priority over every transition and datapath update.

## Timing
- Reset values of outputs: reset=1, all other flags 0, ir_sel=0, ir=0, par_out=0, tdo=0.
- State transitions take one cycle per x sample. The FSM has no wait states.
- cap_in is sampled at the edge ending the CDR cycle.
- A full DR load takes exactly DW SHDR cycles. x=1 on the last cycle still shifts that bit.
- A full IR load takes exactly IRW SHIR cycles.
- In the first SHDR cycle, tdo = bit 0 of the captured channel. Captured bits leave LSB-first on consecutive cycles.
- Bypass adds one cycle of latency from tdi to tdo. The first bit out is 0.
- par_out and ir change at the edge ending the UDR/UIR cycle. They are visible in the following cycle.
- CDR → UDR with no shift writes the captured value back to the channel unchanged.

## Test plan
- rs=1 for 1 cycle, at any time:
  - Next cycle shows reset=1, ir=0, par_out=0, tdo=0.
  - rs=0 with x=0 gives run=1 one cycle later.
- IR load, IRW=3: x sequence 1,1,0,0,0,0,1,0 from RI, with tdi=0,1,0 during the three SHIR cycles.
  - Required: ir=2 after UIR, the FSM returns to RI, and update pulses for exactly 1 cycle.
- DR write to channel 2 (ir=2), cap_in ch2=0x3C: shift 0xA5 LSB-first over 8 SHDR cycles.
  - tdo = 0,0,1,1,1,1,0,0.
  - After UDR, par_out ch2=0xA5 and channels 0, 1, 3 are unchanged.
- Bypass (ir=5): shift tdi=1,0,1 over 3 SHDR cycles.
  - tdo = 0,1,0.
  - par_out is unchanged.
- Starting from each of the 10 states, apply 5 consecutive x=1.
  - Required: state RS, reset=1, ir=0, par_out retained.
- rs=1 mid-SHDR (bit 4 of 8):
  - Next cycle is RS with everything cleared.
  - No partial write reaches par_out.
